// File: rtl/axil_timer.sv
`default_nettype none
// ============================================================================
// Module   : axil_timer
// Summary  : AXI-Lite slave with N_TIMERS independent prescaled down-counting
//            timers, sticky pending flags and registered level interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module axil_timer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int N_TIMERS       = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [N_TIMERS-1:0]   irq,
    output logic                  irq_any
);

    localparam logic [1:0]            c_okay    = 2'b00;
    localparam logic [1:0]            c_slverr  = 2'b10;
    localparam logic [ADDR_WIDTH-4:0] c_glb_blk = (ADDR_WIDTH-3)'(32);
    localparam logic [DATA_WIDTH-1:0] c_info    =
        DATA_WIDTH'({16'd0, 8'(PRESCALE_WIDTH), 8'(N_TIMERS)});

    logic                  r_awready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]            r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [N_TIMERS-1:0]   r_pending, r_irq;
    logic                  r_irq_any;

    logic [DATA_WIDTH-1:0] w_wmask;
    logic [3:0]            w_wa_ch, w_ra_ch;
    logic [1:0]            w_wa_reg, w_ra_reg;
    logic                  w_wa_ch_hit, w_wa_glb, w_ra_ch_hit, w_ra_glb;
    logic [N_TIMERS-1:0]   w_w1c, w_set, w_ie;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_rd_ok;
    logic                  w_unused;

    logic [N_TIMERS-1:0][2:0]                w_ctrl_q;
    logic [N_TIMERS-1:0][PRESCALE_WIDTH-1:0] w_pre_q;
    logic [N_TIMERS-1:0][CNT_WIDTH-1:0]      w_rel_q, w_cnt_q;

    assign w_unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_wmask
        assign w_wmask[8*b +: 8] = {8{s_axil_wstrb[b]}};
    end

    // Channel window is 0x000-0x0FF (16 bytes each); globals live at 0x100/0x104.
    assign w_wa_ch     = s_axil_awaddr[7:4];
    assign w_wa_reg    = s_axil_awaddr[3:2];
    assign w_wa_ch_hit = (s_axil_awaddr[ADDR_WIDTH-1:8] == '0) && ({28'd0, w_wa_ch} < 32'(N_TIMERS));
    assign w_wa_glb    = (s_axil_awaddr[ADDR_WIDTH-1:3] == c_glb_blk);
    assign w_ra_ch     = s_axil_araddr[7:4];
    assign w_ra_reg    = s_axil_araddr[3:2];
    assign w_ra_ch_hit = (s_axil_araddr[ADDR_WIDTH-1:8] == '0) && ({28'd0, w_ra_ch} < 32'(N_TIMERS));
    assign w_ra_glb    = (s_axil_araddr[ADDR_WIDTH-1:3] == c_glb_blk);

    assign w_w1c = (r_awready && w_wa_glb && !s_axil_awaddr[2]) ?
                   (s_axil_wdata[N_TIMERS-1:0] & w_wmask[N_TIMERS-1:0]) : '0;

    for (genvar i = 0; i < N_TIMERS; i++) begin : g_ch
        logic                      r_en, r_oneshot, r_ie;
        logic [PRESCALE_WIDTH-1:0] r_prescale, r_pcnt;
        logic [CNT_WIDTH-1:0]      r_reload, r_count;
        logic                      w_sel, w_wr_ctrl, w_wr_pre, w_wr_rel, w_tick, w_expire;
        logic [2:0]                w_ctrl_new;
        logic [PRESCALE_WIDTH-1:0] w_pre_new;
        logic [CNT_WIDTH-1:0]      w_rel_new;

        assign w_sel     = r_awready && w_wa_ch_hit && (w_wa_ch == 4'(i));
        assign w_wr_ctrl = w_sel && (w_wa_reg == 2'd0);
        assign w_wr_pre  = w_sel && (w_wa_reg == 2'd1);
        assign w_wr_rel  = w_sel && (w_wa_reg == 2'd2);

        assign w_ctrl_new = ({r_ie, r_oneshot, r_en} & ~w_wmask[2:0]) | (s_axil_wdata[2:0] & w_wmask[2:0]);
        assign w_pre_new  = (r_prescale & ~w_wmask[PRESCALE_WIDTH-1:0]) |
                            (s_axil_wdata[PRESCALE_WIDTH-1:0] & w_wmask[PRESCALE_WIDTH-1:0]);
        assign w_rel_new  = (r_reload & ~w_wmask[CNT_WIDTH-1:0]) |
                            (s_axil_wdata[CNT_WIDTH-1:0] & w_wmask[CNT_WIDTH-1:0]);

        assign w_tick   = r_en && (r_pcnt == r_prescale);
        assign w_expire = w_tick && (r_count == '0);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_en       <= 1'b0;
                r_oneshot  <= 1'b0;
                r_ie       <= 1'b0;
                r_prescale <= '0;
                r_pcnt     <= '0;
                r_reload   <= '0;
                r_count    <= '0;
            end else begin
                if (w_wr_ctrl) begin
                    r_en      <= w_ctrl_new[0];
                    r_oneshot <= w_ctrl_new[1];
                    r_ie      <= w_ctrl_new[2];
                end else if (w_expire && r_oneshot) begin
                    r_en <= 1'b0;
                end
                if (w_wr_pre) r_prescale <= w_pre_new;
                if (w_wr_rel) r_reload   <= w_rel_new;

                // An enable edge restarts the period from RELOAD; RELOAD written
                // while running is picked up only at the next expiry.
                if (w_wr_ctrl && w_ctrl_new[0] && !r_en) begin
                    r_count <= r_reload;
                    r_pcnt  <= '0;
                end else if (r_en) begin
                    if (w_tick) begin
                        r_pcnt <= '0;
                        if (r_count != '0)   r_count <= r_count - 1'b1;
                        else if (!r_oneshot) r_count <= r_reload;
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end else if (w_wr_rel) begin
                    r_count <= w_rel_new;
                end
            end
        end

        assign w_set[i]    = w_expire;
        assign w_ie[i]     = r_ie;
        assign w_ctrl_q[i] = {r_ie, r_oneshot, r_en};
        assign w_pre_q[i]  = r_prescale;
        assign w_rel_q[i]  = r_reload;
        assign w_cnt_q[i]  = r_count;
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_ok   = 1'b0;
        if (w_ra_ch_hit) begin
            w_rd_ok = 1'b1;
            for (int k = 0; k < N_TIMERS; k++) begin
                if (w_ra_ch == 4'(k)) begin
                    case (w_ra_reg)
                        2'd0:    w_rd_data = DATA_WIDTH'(w_ctrl_q[k]);
                        2'd1:    w_rd_data = DATA_WIDTH'(w_pre_q[k]);
                        2'd2:    w_rd_data = DATA_WIDTH'(w_rel_q[k]);
                        default: w_rd_data = DATA_WIDTH'(w_cnt_q[k]);
                    endcase
                end
            end
        end else if (w_ra_glb) begin
            w_rd_ok   = 1'b1;
            w_rd_data = s_axil_araddr[2] ? c_info : DATA_WIDTH'(r_pending);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_okay;
        end else begin
            r_awready <= 1'b0;
            if (r_awready) begin
                r_bvalid <= 1'b1;
                r_bresp  <= (w_wa_ch_hit || w_wa_glb) ? c_okay : c_slverr;
            end else if (r_bvalid) begin
                if (s_axil_bready) r_bvalid <= 1'b0;
            end else if (s_axil_awvalid && s_axil_wvalid) begin
                r_awready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_okay;
            r_rdata   <= '0;
        end else begin
            r_arready <= 1'b0;
            if (r_arready) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_rd_ok ? c_okay : c_slverr;
                r_rdata  <= w_rd_data;
            end else if (r_rvalid) begin
                if (s_axil_rready) r_rvalid <= 1'b0;
            end else if (s_axil_arvalid) begin
                r_arready <= 1'b1;
            end
        end
    end

    // Hardware set is OR-ed in after the W1C mask so a coincident set survives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= '0;
            r_irq     <= '0;
            r_irq_any <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_w1c) | w_set;
            r_irq     <= r_pending & w_ie;
            r_irq_any <= |(r_pending & w_ie);
        end
    end

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_awready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rresp   = r_rresp;
    assign s_axil_rdata   = r_rdata;
    assign irq            = r_irq;
    assign irq_any        = r_irq_any;

endmodule
`default_nettype wire

// File: tb/tb_axil_timer.sv
`default_nettype none
// Bench for axil_timer: directed map/handshake cases plus randomized channel
// programming checked against a period/tick-count model of each timer.
module tb_axil_timer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, irq_any;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [3:0]  irq;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          last_rise [4];
    logic [3:0]  irq_prev = '0;
    int          wr_commit, rd_accept;
    logic [31:0] d;
    logic [1:0]  resp;
    int          t0, bad, n;

    axil_timer dut (
        .clk(clk), .rstn(rstn),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'd0), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(3'd0), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .irq(irq), .irq_any(irq_any)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Records the edge index at which each irq line was last seen rising.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (irq[i] && !irq_prev[i]) last_rise[i] = cyc;
        irq_prev = irq;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] dv, input logic [3:0] s,
                             output logic [1:0] rsp);
        int k = 0;
        awaddr = a; wdata = dv; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        do begin tick(); k++; end while (!awready && k < 40);
        if (!awready) check("aw_timeout", {31'd0, awready}, 1);
        wr_commit = cyc + 1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        k = 0;
        while (!bvalid && k < 40) begin tick(); k++; end
        if (!bvalid) check("b_timeout", {31'd0, bvalid}, 1);
        rsp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] dv, output logic [1:0] rsp);
        int k = 0;
        araddr = a; arvalid = 1'b1;
        do begin tick(); k++; end while (!arready && k < 40);
        if (!arready) check("ar_timeout", {31'd0, arready}, 1);
        rd_accept = cyc;
        tick();
        arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 40) begin tick(); k++; end
        if (!rvalid) check("r_timeout", {31'd0, rvalid}, 1);
        dv = rdata; rsp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    // COUNT after e edges since the enable edge: ticks fall every p+1 edges,
    // periodic mode cycles r..0, one-shot stops at 0.
    function automatic int model_count(input int e, input int p, input int r, input bit os);
        int nt;
        nt = e / (p + 1);
        if (os) return (nt <= r) ? r - nt : 0;
        return r - (nt % (r + 1));
    endfunction

    task automatic run_chan(input int ch, input int p, input int r, input bit os);
        int          per, te, tdis;
        logic [31:0] v;
        logic [1:0]  rs;
        logic [11:0] base;
        base = 12'(ch * 16);
        per  = (p + 1) * (r + 1);
        axi_write(base + 12'h4, 32'(p), 4'hF, rs);
        axi_write(base + 12'h8, 32'(r), 4'hF, rs);
        axi_read(base + 12'hC, v, rs);
        check("count_preload", v, 32'(r));
        axi_write(base, os ? 32'h7 : 32'h5, 4'hF, rs);
        check("ctrl_bresp", {30'd0, rs}, 0);
        te = wr_commit;
        repeat ($urandom_range(0, per + 4)) tick();
        axi_read(base + 12'hC, v, rs);
        check("count_mid", v, 32'(model_count(rd_accept - te, p, r, os)));
        while (cyc < te + per + 3) tick();
        check("irq_rise", 32'(last_rise[ch]), 32'(te + per + 1));
        check("irq_vec", {28'd0, irq}, 32'(1 << ch));
        check("irq_any", {31'd0, irq_any}, 1);
        if (os) begin
            axi_read(base, v, rs);
            check("oneshot_ctrl", v, 32'h6);
            repeat (50) tick();
            axi_read(base + 12'hC, v, rs);
            check("oneshot_count", v, 0);
            check("oneshot_no_rerise", 32'(last_rise[ch]), 32'(te + per + 1));
            axi_write(base, 32'h2, 4'hF, rs);
            repeat (2) tick();
            check("ie_off_irq", {28'd0, irq}, 0);
        end else begin
            repeat ($urandom_range(0, 2 * per)) tick();
            axi_read(base + 12'hC, v, rs);
            check("count_late", v, 32'(model_count(rd_accept - te, p, r, os)));
            axi_write(base, 32'h4, 4'hF, rs);
            tdis = wr_commit;
            repeat ($urandom_range(1, 6)) tick();
            axi_read(base + 12'hC, v, rs);
            check("count_frozen", v, 32'(model_count(tdis - te, p, r, os)));
        end
        axi_read(12'h100, v, rs);
        check("status_set", v, 32'(1 << ch));
        axi_write(12'h100, 32'hF, 4'hF, rs);
        axi_write(base, 32'h0, 4'hF, rs);
        axi_read(12'h100, v, rs);
        check("status_clr", v, 0);
    endtask

    initial begin
        // Reset and a reset landing in the middle of a write handshake.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {18'd0, awready, wready, bvalid, arready, rvalid, irq, irq_any, bresp, rresp}, 0);
        rstn = 1'b1;
        tick();
        awaddr = 12'h000; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        #2 rstn = 1'b0;
        #1;
        check("midreset_outs", {18'd0, awready, wready, bvalid, arready, rvalid, irq, irq_any, bresp, rresp}, 0);
        check("midreset_rdata", rdata, 0);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        axi_read(12'h104, d, resp);
        check("info", d, 32'h0000_1004);
        check("info_rresp", {30'd0, resp}, 0);
        axi_read(12'h000, d, resp);
        check("ctrl_after_reset", d, 0);

        // Periodic ch0 with a W1C timed onto the hardware set edge.
        axi_write(12'h004, 32'd1, 4'hF, resp);
        axi_write(12'h008, 32'd4, 4'hF, resp);
        axi_write(12'h000, 32'h5, 4'hF, resp);
        t0 = wr_commit;
        while (cyc < t0 + 13) tick();
        check("per_rise1", 32'(last_rise[0]), 32'(t0 + 11));
        axi_write(12'h100, 32'h1, 4'hF, resp);
        while (cyc < t0 + 23) tick();
        check("per_rise2", 32'(last_rise[0]), 32'(t0 + 21));
        axi_write(12'h100, 32'h1, 4'hF, resp);
        while (cyc < t0 + 28) tick();
        axi_write(12'h100, 32'h1, 4'hF, resp);
        check("collide_edge", 32'(wr_commit), 32'(t0 + 30));
        axi_read(12'h100, d, resp);
        check("collide_status", d & 32'h1, 32'h1);
        check("collide_irq", {31'd0, irq[0]}, 1);
        check("collide_rise", 32'(last_rise[0]), 32'(t0 + 31));
        axi_write(12'h000, 32'h0, 4'hF, resp);
        axi_write(12'h100, 32'hF, 4'hF, resp);

        // One-shot ch1.
        run_chan(1, 0, 3, 1'b1);

        // Write backpressure with partial strobes on ch2 RELOAD.
        awaddr = 12'h028; wdata = 32'hAABB_CCDD; wstrb = 4'h3; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!awready && n < 40);
        tick();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (!bvalid || awready) bad++;
            tick();
        end
        check("bp_write_hold", 32'(bad), 0);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_bresp", {30'd0, bresp}, 0);
        bready = 1'b1; tick(); bready = 1'b0;
        check("bp_bvalid_drop", {31'd0, bvalid}, 0);

        // Read backpressure.
        araddr = 12'h028; arvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!arready && n < 40);
        tick();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (!rvalid || arready) bad++;
            tick();
        end
        check("bp_read_hold", 32'(bad), 0);
        arvalid = 1'b0;
        check("bp_rdata", rdata, 32'h0000_CCDD);
        rready = 1'b1; tick(); rready = 1'b0;
        check("bp_rvalid_drop", {31'd0, rvalid}, 0);

        // Decode errors and read-only registers.
        axi_read(12'h040, d, resp);
        check("unmapped_ch_rresp", {30'd0, resp}, 2);
        check("unmapped_ch_rdata", d, 0);
        axi_write(12'h108, 32'hFFFF_FFFF, 4'hF, resp);
        check("unmapped_bresp", {30'd0, resp}, 2);
        axi_write(12'h02C, 32'h1234_5678, 4'hF, resp);
        check("count_wr_okay", {30'd0, resp}, 0);
        axi_read(12'h02C, d, resp);
        check("count_wr_ignored", d, 32'h0000_CCDD);
        axi_read(12'h200, d, resp);
        check("unmapped_hi_rresp", {30'd0, resp}, 2);
        axi_read(12'h028, d, resp);
        check("reload_unchanged", d, 32'h0000_CCDD);
        axi_read(12'h100, d, resp);
        check("status_unchanged", d, 0);

        // Randomized channel programming.
        for (int it = 0; it < 6; it++) begin
            run_chan(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_timer.md
Name: axil_timer

Overview:
- AXI-Lite slave peripheral with N_TIMERS independent down-counting timers, each with its own prescaler, reload value, periodic/one-shot mode and interrupt enable.
- Sits as an additional interconnect master port beside UART and GPIO at base 0x0400_2000, 4KB window. It replaces the free-running heartbeat counter with software-programmable timing and interrupts.

Parameters:
DATA_WIDTH, 32, AXI data width (only 32 supported)
ADDR_WIDTH, 12, local byte-address width
STRB_WIDTH, DATA_WIDTH/8, write strobe width
N_TIMERS, 4, number of timer channels (1..16)
CNT_WIDTH, 32, counter/reload width (1..32; upper read bits zero)
PRESCALE_WIDTH, 16, prescaler width (1..32)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
s_axil_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel (awprot ignored)
s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  write data channel
s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
s_axil_araddr/arprot/arvalid/arready  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel (arprot ignored)
s_axil_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel
irq  output  N_TIMERS  per-channel interrupt, level, registered
irq_any  output  1  OR of irq, registered

Behaviour:
- Reset (rstn low, async): all CTRL/PRESCALE/RELOAD/COUNT/prescaler counters/PENDING = 0. awready, wready, bvalid, arready, rvalid, irq, irq_any = 0. bresp, rresp, rdata = 0. Reset mid-transaction drops the transaction; no response is issued.
- Register map, channel i at 0x10*i:
  - +0x0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IE.
  - +0x4 PRESCALE.
  - +0x8 RELOAD.
  - +0xC COUNT (read-only; writes ignored, OKAY).
- Global registers: 0x100 STATUS = PENDING[N_TIMERS-1:0], write-1-to-clear. 0x104 INFO = {16'd0, 8'(PRESCALE_WIDTH), 8'(N_TIMERS)}, read-only.
- Any other address, or channel index >= N_TIMERS: write ignored, read data 0, resp SLVERR (2'b10). All mapped accesses return OKAY.
- Write handshake:
  - Accept only when awvalid && wvalid && !bvalid. awready and wready pulse high together for exactly one cycle.
  - Register update and bvalid both occur on the next edge. bvalid holds until bready; no new write is accepted while bvalid is high.
  - wstrb is honoured per byte on CTRL, PRESCALE and RELOAD.
- Read handshake:
  - Accept when arvalid && !rvalid. arready pulses one cycle.
  - rvalid and rdata are registered on the next edge. rdata reflects register state at the accept edge. rvalid holds until rready.
  - Reads and writes are independent; both may complete in the same cycle.
- Timer, per channel, when EN = 1:
  - The prescaler counter increments each cycle. When it equals PRESCALE it wraps to 0 and produces a tick; PRESCALE = 0 ticks every cycle.
  - On a tick with COUNT != 0: COUNT decrements.
  - On a tick with COUNT == 0: PENDING[i] is set. In periodic mode COUNT is loaded from RELOAD. In one-shot mode EN is cleared and COUNT stays 0.
  - Period = (PRESCALE+1)*(RELOAD+1) cycles.
- EN write 0->1: COUNT is loaded from RELOAD and the prescaler counter is cleared on the same edge. The first tick follows PRESCALE+1 cycles later.
- EN = 0: counters freeze. Writing RELOAD while EN = 0 also loads COUNT. Writing RELOAD while EN = 1 takes effect at the next reload only.
- Simultaneous hardware set and software W1C on the same PENDING bit: the set wins (bit remains 1).
- irq[i] = registered (PENDING[i] & IE[i]), asserted the cycle after PENDING sets. irq_any is registered from the same term, so irq and irq_any align.
- Clearing IE deasserts irq without clearing PENDING.

Test Plan:
- Reset: drive rstn low mid-write with awvalid/wvalid high -> all outputs 0. Read 0x104 after release -> 0x0000_1004 (defaults), OKAY.
- Periodic: ch0 PRESCALE = 1, RELOAD = 4, CTRL = 0x5 -> PENDING[0] sets every 10 cycles. irq[0] rises one cycle later. Write 0x1 to 0x100 clears it; it re-sets 10 cycles after the previous set.
- One-shot: ch1 PRESCALE = 0, RELOAD = 3, CTRL = 0x7 -> PENDING[1] after 4 ticks. CTRL reads back 0x6, COUNT reads 0, no further events over 50 cycles.
- Collision: time a W1C of PENDING[0] to coincide with its hardware set -> STATUS still reads bit0 = 1 and irq[0] stays high.
- Backpressure/strobes: hold bready/rready low 5 cycles -> bvalid/rvalid held and no second accept. Write RELOAD 0xAABBCCDD with wstrb 0x3 over 0 -> reads 0x0000CCDD.
- Decode: read 0x040 with N_TIMERS = 4, and write 0x108 -> rresp/bresp = SLVERR, rdata 0, no register changed.
